pq_vec_modaddsub: RTL and testbench

- Pipelined, multi-lane modular add/subtract unit for the PQ ALU.
- Each transaction carries LANES packed coefficients per operand, a shared modulus q and an add/sub mode.
- Every lane computes (a ± b) mod q with full carry/borrow handling over the complete DATA_WIDTH range.
- Sits between the WDR operand fetch and the result writeback; uses valid/ready handshakes on both sides; fixed 2-cycle latency; throughput one transaction per cycle.

---
 rtl/pq_alu_pkg.sv | 15 +
 rtl/pq_vec_modaddsub_if.sv | 29 ++
 rtl/pq_modaddsub_lane.sv | 45 ++++
 rtl/pq_vec_modaddsub.sv | 111 +++++++++++
 tb/tb_pq_vec_modaddsub.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pq_alu_pkg.sv
// Shared PQ ALU types and constants: add/sub mode encoding, default coefficient
// type and the Kyber/Dilithium moduli.
package pq_alu_pkg;

  localparam int PQ_DATA_WIDTH = 32;
  localparam int PQ_LANES      = 8;

  typedef enum logic {PQ_ADD = 1'b0, PQ_SUB = 1'b1} pq_addsub_mode_e;

  typedef logic [PQ_DATA_WIDTH-1:0] coeff_t;

  localparam coeff_t KYBER_Q     = 32'd3329;
  localparam coeff_t DILITHIUM_Q = 32'd8380417;

endpackage

// File: rtl/pq_vec_modaddsub_if.sv
// Operand/result handshake bundle for pq_vec_modaddsub. The slave modport is the
// unit itself; the master modport is the fetch/writeback side.
interface pq_vec_modaddsub_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 8
);

  logic                        in_valid_i;
  logic                        in_ready_o;
  logic                        mode_i;
  logic [DATA_WIDTH-1:0]       q_i;
  logic [LANES*DATA_WIDTH-1:0] op0_i;
  logic [LANES*DATA_WIDTH-1:0] op1_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [LANES*DATA_WIDTH-1:0] res_o;
  logic                        err_o;

  modport slave (
    input  in_valid_i, mode_i, q_i, op0_i, op1_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, err_o
  );

  modport master (
    output in_valid_i, mode_i, q_i, op0_i, op1_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, err_o
  );

endinterface

// File: rtl/pq_modaddsub_lane.sv
// Combinational single-lane modular add/sub front end: raw result, corrected
// candidate and a borrow bit; range flag only with PQ_MODADDSUB_RANGE_CHECK_EN.
module pq_modaddsub_lane
  import pq_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] q_i,
  input  pq_addsub_mode_e       mode_i,
  output logic [DATA_WIDTH-1:0] raw_o,
  output logic [DATA_WIDTH-1:0] corr_o,
`ifdef PQ_MODADDSUB_RANGE_CHECK_EN
  output logic                  rng_o,
`endif
  output logic                  brw_o
);

  localparam int W = DATA_WIDTH;

  logic [W:0]   sum;
  logic [W-1:0] dif;

  // brw_o is a borrow in both modes: add -> (s < q), sub -> (a < b).
  // The stage-2 select inverts it for add, so the corrected value wins on no-borrow.
  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    dif = a_i - b_i;
    if (mode_i == PQ_ADD) begin
      raw_o  = sum[W-1:0];
      corr_o = sum[W-1:0] - q_i;
      brw_o  = (sum < {1'b0, q_i});
    end else begin
      raw_o  = dif;
      corr_o = dif + q_i;
      brw_o  = (a_i < b_i);
    end
  end

`ifdef PQ_MODADDSUB_RANGE_CHECK_EN
  assign rng_o = (a_i >= q_i) | (b_i >= q_i);
`endif

endmodule

// File: rtl/pq_vec_modaddsub.sv
// Two-stage elastic multi-lane modular add/sub unit. Optional operand range
// checking is built with PQ_MODADDSUB_RANGE_CHECK_EN; otherwise err_o is 0.
module pq_vec_modaddsub
  import pq_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  pq_vec_modaddsub_if.slave       bus
);

  localparam int W = DATA_WIDTH;

  logic v1_q, v1_d, v2_q, v2_d;
  logic s2_rdy, in_rdy, ld1, ld2;

  logic [LANES*W-1:0] raw_d,  raw_q;
  logic [LANES*W-1:0] corr_d, corr_q;
  logic [LANES-1:0]   brw_d,  brw_q;
  pq_addsub_mode_e    mode_d, mode_q;
  logic [LANES*W-1:0] res_d,  res_q;

  assign mode_d = pq_addsub_mode_e'(bus.mode_i);

  assign s2_rdy = !v2_q | bus.out_ready_i;
  assign in_rdy = !v1_q | s2_rdy;
  assign ld1    = in_rdy & bus.in_valid_i;
  assign ld2    = s2_rdy & v1_q;

  assign v1_d = in_rdy ? bus.in_valid_i : v1_q;
  assign v2_d = s2_rdy ? v1_q : v2_q;

`ifdef PQ_MODADDSUB_RANGE_CHECK_EN
  logic [LANES-1:0] rng_d, rng_q;
  logic             qlow_q, err_q;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pq_modaddsub_lane #(.DATA_WIDTH(W)) u_lane (
      .a_i    (bus.op0_i[k*W +: W]),
      .b_i    (bus.op1_i[k*W +: W]),
      .q_i    (bus.q_i),
      .mode_i (mode_d),
      .raw_o  (raw_d[k*W +: W]),
      .corr_o (corr_d[k*W +: W]),
`ifdef PQ_MODADDSUB_RANGE_CHECK_EN
      .rng_o  (rng_d[k]),
`endif
      .brw_o  (brw_d[k])
    );
  end

  always_comb begin
    logic sel;
    sel   = 1'b0;
    res_d = '0;
    for (int k = 0; k < LANES; k++) begin
      sel = (mode_q == PQ_SUB) ? brw_q[k] : !brw_q[k];
      res_d[k*W +: W] = sel ? corr_q[k*W +: W] : raw_q[k*W +: W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      raw_q  <= '0;
      corr_q <= '0;
      brw_q  <= '0;
      mode_q <= PQ_ADD;
      res_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (ld1) begin
        raw_q  <= raw_d;
        corr_q <= corr_d;
        brw_q  <= brw_d;
        mode_q <= mode_d;
      end
      if (ld2) res_q <= res_d;
    end
  end

`ifdef PQ_MODADDSUB_RANGE_CHECK_EN
  // Flags travel beside the data so err_o stays aligned with res_o under stall.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rng_q  <= '0;
      qlow_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (ld1) begin
        rng_q  <= rng_d;
        qlow_q <= (bus.q_i < W'(2));
      end
      if (ld2) err_q <= (|rng_q) | qlow_q;
    end
  end
  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.in_ready_o  = in_rdy;
  assign bus.out_valid_o = v2_q;
  assign bus.res_o       = res_q;

endmodule

// File: tb/tb_pq_vec_modaddsub.sv
// Scoreboard bench for pq_vec_modaddsub; honours PQ_MODADDSUB_RANGE_CHECK_EN when
// deciding what err_o must be.
module tb_pq_vec_modaddsub;
  import pq_alu_pkg::*;

  localparam int DW = 32;
  localparam int L  = 8;

  typedef logic [DW-1:0]   word_t;
  typedef logic [L*DW-1:0] vec_t;
  typedef struct { vec_t res; logic err; } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_ret  = 0;
  int occ    = 0;
  exp_t sb[$];

  pq_vec_modaddsub_if #(.DATA_WIDTH(DW), .LANES(L)) bus ();

  pq_vec_modaddsub #(.DATA_WIDTH(DW), .LANES(L)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic word_t model_lane(logic mode, word_t q, word_t a, word_t b);
    logic [DW:0] t;
    if (!mode) begin
      t = {1'b0, a} + {1'b0, b};
      if (t >= {1'b0, q}) t = t - {1'b0, q};
    end else begin
      t = {1'b0, a} - {1'b0, b};
      if (a < b) t = t + {1'b0, q};
    end
    return t[DW-1:0];
  endfunction

  function automatic exp_t model(logic mode, word_t q, vec_t a, vec_t b);
    exp_t e;
    e.res = '0;
    e.err = 1'b0;
    for (int k = 0; k < L; k++) begin
      e.res[k*DW +: DW] = model_lane(mode, q, a[k*DW +: DW], b[k*DW +: DW]);
`ifdef PQ_MODADDSUB_RANGE_CHECK_EN
      if (a[k*DW +: DW] >= q || b[k*DW +: DW] >= q) e.err = 1'b1;
`endif
    end
`ifdef PQ_MODADDSUB_RANGE_CHECK_EN
    if (q < 2) e.err = 1'b1;
`endif
    return e;
  endfunction

  // Pipeline occupancy before this cycle's edge, taken before any push/pop.
  always @(negedge clk) begin
    #1;
    occ = sb.size();
  end

  logic prev_stall = 1'b0;
  vec_t prev_res   = '0;
  exp_t mon_e;

  always @(negedge clk) begin
    #3;
    if (prev_stall) begin
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.res_o !== prev_res) begin
        errors++;
        $display("FAIL hold_under_stall: valid=%b res=%h, required valid=1 res=%h",
                 bus.out_valid_o, bus.res_o, prev_res);
      end
    end
    prev_stall = rst_n && bus.out_valid_o && !bus.out_ready_i;
    prev_res   = bus.res_o;
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      n_ret++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: res=%h appeared, required no output", bus.res_o);
      end else begin
        mon_e = sb.pop_front();
        if (bus.res_o !== mon_e.res || bus.err_o !== mon_e.err) begin
          errors++;
          $display("FAIL scoreboard: res=%h err=%b, required res=%h err=%b",
                   bus.res_o, bus.err_o, mon_e.res, mon_e.err);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic mode, input word_t q, input vec_t a, input vec_t b);
    bus.mode_i     = mode;
    bus.q_i        = q;
    bus.op0_i      = a;
    bus.op1_i      = b;
    bus.in_valid_i = 1'b1;
  endtask

  task automatic step(output bit acc);
    #4;
    acc = rst_n && bus.in_valid_i && bus.in_ready_o;
    if (acc) sb.push_back(model(bus.mode_i, bus.q_i, bus.op0_i, bus.op1_i));
    @(negedge clk);
  endtask

  task automatic send(input logic mode, input word_t q, input vec_t a, input vec_t b);
    bit acc;
    acc = 1'b0;
    drive(mode, q, a, b);
    for (int i = 0; i < 20; i++) begin
      step(acc);
      if (acc) break;
    end
    bus.in_valid_i = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: accepted=%b, required 1", acc);
    end
  endtask

  // Leaves the caller at +4 inside a cycle where out_valid_o is high (or timed out).
  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #4;
      if (bus.out_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL out_timeout: out_valid=%b, required 1", bus.out_valid_o);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    bus.in_valid_i  = 1'b0;
    bus.mode_i      = 1'b0;
    bus.q_i         = '0;
    bus.op0_i       = '0;
    bus.op1_i       = '0;
    bus.out_ready_i = 1'b1;
    rst_n           = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #4;
    checks++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 ||
        bus.res_o !== '0 || bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b res=%h err=%b, required 1 0 0 0",
               bus.in_ready_o, bus.out_valid_o, bus.res_o, bus.err_o);
    end
    @(negedge clk);
  endtask

  task automatic test_add_wrap();
    vec_t a, b;
    for (int k = 0; k < L; k++) begin
      a[k*DW +: DW] = 32'd3328;
      b[k*DW +: DW] = 32'd1;
    end
    send(1'b0, KYBER_Q, a, b);
    #4;
    checks++;
    if (bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b one cycle after accept, required 0", bus.out_valid_o);
    end
    @(negedge clk);
    #4;
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.res_o !== '0) begin
      errors++;
      $display("FAIL add_wrap: out_valid=%b res=%h two cycles after accept, required 1 and 0",
               bus.out_valid_o, bus.res_o);
    end
    @(negedge clk);
  endtask

  task automatic test_sub();
    vec_t a, b;
    bit ok;
    for (int k = 0; k < L; k++) begin
      a[k*DW +: DW] = word_t'(k * 100);
      b[k*DW +: DW] = word_t'(k * 7);
    end
    a[0 +: DW]  = 32'd0;  b[0 +: DW]  = 32'd1;
    a[DW +: DW] = 32'd5;  b[DW +: DW] = 32'd3;
    send(1'b1, KYBER_Q, a, b);
    wait_out(ok);
    checks++;
    if (bus.res_o[0 +: DW] !== 32'd3328 || bus.res_o[DW +: DW] !== 32'd2) begin
      errors++;
      $display("FAIL sub_borrow: lane0=%0d lane1=%0d, required 3328 and 2",
               bus.res_o[0 +: DW], bus.res_o[DW +: DW]);
    end
    @(negedge clk);
  endtask

  task automatic test_carry();
    vec_t a, exp_v;
    bit ok;
    for (int k = 0; k < L; k++) begin
      a[k*DW +: DW]     = 32'hFFFF_FFFA;
      exp_v[k*DW +: DW] = 32'hFFFF_FFF9;
    end
    send(1'b0, 32'hFFFF_FFFB, a, a);
    wait_out(ok);
    checks++;
    if (bus.res_o !== exp_v) begin
      errors++;
      $display("FAIL add_carry: res=%h, required %h", bus.res_o, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    vec_t ta [10];
    vec_t tb [10];
    logic tm [10];
    int idx, last_acc, ret0, c;
    bit saw_block;
    for (int i = 0; i < 10; i++) begin
      tm[i] = 1'(i % 2);
      for (int k = 0; k < L; k++) begin
        ta[i][k*DW +: DW] = word_t'($urandom_range(DILITHIUM_Q - 1));
        tb[i][k*DW +: DW] = word_t'($urandom_range(DILITHIUM_Q - 1));
      end
    end
    idx = 0; last_acc = -1; saw_block = 1'b0; ret0 = n_ret;
    for (c = 0; c < 60; c++) begin
      bus.out_ready_i = !(c >= 3 && c <= 7);
      if (idx < 10) drive(tm[idx], DILITHIUM_Q, ta[idx], tb[idx]);
      else bus.in_valid_i = 1'b0;
      #4;
      checks++;
      if (bus.in_ready_o !== !(occ >= 2 && !bus.out_ready_i)) begin
        errors++;
        $display("FAIL b2b_in_ready: cycle %0d in_ready=%b, required %b",
                 c, bus.in_ready_o, !(occ >= 2 && !bus.out_ready_i));
      end
      if (!bus.in_ready_o) saw_block = 1'b1;
      if (bus.in_valid_i && bus.in_ready_o) begin
        sb.push_back(model(bus.mode_i, bus.q_i, bus.op0_i, bus.op1_i));
        idx++;
        last_acc = c;
      end
      @(negedge clk);
      if (idx == 10 && sb.size() == 0) break;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    checks++;
    if (!saw_block || last_acc != 14) begin
      errors++;
      $display("FAIL b2b_throughput: blocked=%b last_accept_cycle=%0d, required 1 and 14",
               saw_block, last_acc);
    end
    checks++;
    if (n_ret - ret0 != 10 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: retired=%0d pending=%0d, required 10 and 0",
               n_ret - ret0, sb.size());
    end
  endtask

  task automatic test_random();
    int idx;
    idx = 0;
    for (int c = 0; c < 300 && idx < 16; c++) begin
      word_t q;
      vec_t a, b;
      bus.out_ready_i = ($urandom_range(3) != 0);
      if (!bus.in_valid_i) begin
        q = word_t'($urandom);
        if (q < 2) q = 2;
        for (int k = 0; k < L; k++) begin
          a[k*DW +: DW] = word_t'($urandom_range(q - 1));
          b[k*DW +: DW] = word_t'($urandom_range(q - 1));
        end
        drive(1'($urandom_range(1)), q, a, b);
      end
      #4;
      if (bus.in_valid_i && bus.in_ready_o) begin
        sb.push_back(model(bus.mode_i, bus.q_i, bus.op0_i, bus.op1_i));
        idx++;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    drain();
  endtask

  task automatic test_reset_inflight();
    vec_t a, b;
    int ret0;
    bit acc;
    for (int k = 0; k < L; k++) begin
      a[k*DW +: DW] = word_t'(k + 10);
      b[k*DW +: DW] = word_t'(k + 1);
    end
    drive(1'b0, KYBER_Q, a, b);
    step(acc);
    drive(1'b1, KYBER_Q, a, b);
    step(acc);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    rst_n           = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    bus.out_ready_i = 1'b1;
    ret0 = n_ret;
    #4;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.res_o !== '0 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_flush: out_valid=%b res=%h in_ready=%b, required 0 0 1",
               bus.out_valid_o, bus.res_o, bus.in_ready_o);
    end
    @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (n_ret != ret0) begin
      errors++;
      $display("FAIL reset_discard: %0d outputs after reset, required 0", n_ret - ret0);
    end
    send(1'b0, KYBER_Q, a, b);
    drain();
  endtask

  task automatic test_range();
    vec_t a, b;
    bit ok;
    logic exp_err;
    for (int k = 0; k < L; k++) begin
      a[k*DW +: DW] = 32'd10;
      b[k*DW +: DW] = 32'd20;
    end
    a[3*DW +: DW] = 32'd3329;
`ifdef PQ_MODADDSUB_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send(1'b0, KYBER_Q, a, b);
    wait_out(ok);
    checks++;
    if (bus.err_o !== exp_err) begin
      errors++;
      $display("FAIL range_err: err=%b, required %b", bus.err_o, exp_err);
    end
    @(negedge clk);
    drain();
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_carry();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    test_range();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_pending: pending=%0d, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
